// File: rtl/aip_host_pkg.sv
// Shared encodings for the AIP host sequencer: command opcodes, FSM states
// and the conf_dbus codes of the standard AIP wrapper registers.
package aip_host_pkg;

  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_START    = 2'd2;
  localparam logic [1:0] OP_WAIT_INT = 2'd3;

  localparam logic [4:0] CFG_MEMOUT0 = 5'd0;
  localparam logic [4:0] CFG_MEMIN0  = 5'd1;
  localparam logic [4:0] CFG_CONFREG = 5'd3;
  localparam logic [4:0] CFG_STATUS  = 5'd30;
  localparam logic [4:0] CFG_IPID    = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_START,
    ST_WAIT_INT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/aip_host_timeout.sv
// Loadable down-counter for the WAIT_INT timeout; expired is high once the
// count has reached zero and stays there until the next load.
module aip_host_timeout #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/aip_host_seq.sv
// AIP host-side initiator: turns one command into a sequenced burst write,
// burst read, start pulse or interrupt wait on the AIP configuration bus.
module aip_host_seq
  import aip_host_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int CFG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  en_s,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CFG_WIDTH-1:0]  cmd_cfg,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] aip_data_out,
  input  logic [DATA_WIDTH-1:0] aip_data_in,
  output logic [CFG_WIDTH-1:0]  aip_conf_dbus,
  output logic                  aip_write,
  output logic                  aip_read,
  output logic                  aip_start,
  input  logic                  aip_int_req
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  logic                    init_q;
  logic [1:0]              op_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic                    err_q;
  logic [CFG_WIDTH-1:0]    conf_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_vld_q;
  logic                    to_load, to_dec, to_expired;

  aip_host_timeout #(.CNT_W(TO_W)) u_timeout (
    .clk      (clk),
    .rst_a    (rst_a),
    .load     (to_load),
    .dec      (to_dec),
    .load_val (TO_LOAD),
    .expired  (to_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    aip_write    = 1'b0;
    aip_read     = 1'b0;
    aip_start    = 1'b0;
    aip_data_out = '0;
    done         = 1'b0;
    err          = 1'b0;
    to_load      = 1'b0;
    to_dec       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = init_q;
        if (cmd_valid && init_q) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        to_load = 1'b1;
        case (op_q)
          OP_WRITE: state_d = (len_q == '0) ? ST_DONE : ST_WRITE;
          OP_READ:  state_d = (len_q == '0) ? ST_DONE : ST_READ;
          OP_START: state_d = ST_START;
          default:  state_d = ST_WAIT_INT;
        endcase
      end
      ST_WRITE: begin
        aip_write    = wr_valid;
        wr_ready     = wr_valid;
        aip_data_out = wr_data;
        if (wr_valid && (cnt_q == len_q - 1'b1)) state_d = ST_DONE;
      end
      ST_READ: begin
        aip_read = 1'b1;
        if (cnt_q == len_q - 1'b1) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_START: begin
        aip_start = 1'b1;
        state_d   = ST_DONE;
      end
      ST_WAIT_INT: begin
        to_dec = 1'b1;
        if (aip_int_req || ((TIMEOUT_CYCLES != 0) && to_expired)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A disabled cycle freezes everything and suppresses every strobe.
    if (!en_s) begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      aip_write = 1'b0;
      aip_read  = 1'b0;
      aip_start = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      to_load   = 1'b0;
      to_dec    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= ST_IDLE;
      init_q    <= 1'b0;
      op_q      <= OP_WRITE;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      conf_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      init_q <= 1'b1;
      if (en_s) begin
        state_q  <= state_d;
        rd_vld_q <= aip_read;
        if (aip_read) rd_data_q <= aip_data_in;
        if (aip_write || aip_read) cnt_q <= cnt_q + 1'b1;
        if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) begin
          op_q   <= cmd_op;
          len_q  <= cmd_len;
          conf_q <= cmd_cfg;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end
        // Interrupt wins over a coinciding timeout.
        if ((state_q == ST_WAIT_INT) && (state_d == ST_DONE)) err_q <= !aip_int_req;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) conf_q <= '0;
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_vld_q & en_s;
  assign aip_conf_dbus = conf_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aip_host_seq.sv
// Bench for aip_host_seq: directed and randomized commands, with a cycle-stamped
// monitor compared against expectations derived from the command rules.
module tb_aip_host_seq;
  import aip_host_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_a, en_s, cmd_valid, cmd_valid_to, wr_valid, aip_int_req;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cfg;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, aip_data_in;

  logic          cmd_ready, wr_ready, rd_valid, done, err, busy, aip_write, aip_read, aip_start;
  logic [DW-1:0] rd_data, aip_data_out;
  logic [CW-1:0] aip_conf_dbus;

  logic          cmd_ready_t, wr_ready_t, rd_valid_t, done_t, err_t, busy_t, aip_write_t, aip_read_t, aip_start_t;
  logic [DW-1:0] rd_data_t, aip_data_out_t;
  logic [CW-1:0] aip_conf_dbus_t;

  always #5 clk = ~clk;

  aip_host_seq dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cfg(cmd_cfg), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
    .aip_data_out(aip_data_out), .aip_data_in(aip_data_in), .aip_conf_dbus(aip_conf_dbus),
    .aip_write(aip_write), .aip_read(aip_read), .aip_start(aip_start), .aip_int_req(aip_int_req)
  );

  aip_host_seq #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .cmd_valid(cmd_valid_to), .cmd_ready(cmd_ready_t),
    .cmd_op(cmd_op), .cmd_cfg(cmd_cfg), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_t), .rd_data(rd_data_t), .rd_valid(rd_valid_t), .done(done_t), .err(err_t),
    .busy(busy_t), .aip_data_out(aip_data_out_t), .aip_data_in(aip_data_in),
    .aip_conf_dbus(aip_conf_dbus_t), .aip_write(aip_write_t), .aip_read(aip_read_t),
    .aip_start(aip_start_t), .aip_int_req(aip_int_req)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic [CW-1:0] cfg;
  } ev_t;

  ev_t  wq[$], rq[$], vq[$];
  int   sq[$], dq[$], d2q[$];
  logic eq[$], e2q[$];
  int   cyc = 0;
  int   viol = 0;
  int   rd_idx = 0;
  logic [DW-1:0] dbase = '0;
  int   checks = 0;
  int   errors = 0;

  // AIP memory model: word n of the current burst reads back as dbase + n.
  assign aip_data_in = dbase + DW'(rd_idx);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aip_read) rd_idx <= rd_idx + 1;
  end

  always @(negedge clk) begin
    if (aip_write) wq.push_back('{cyc, aip_data_out, aip_conf_dbus});
    if (aip_read)  rq.push_back('{cyc, '0, aip_conf_dbus});
    if (rd_valid)  vq.push_back('{cyc, rd_data, aip_conf_dbus});
    if (aip_start) sq.push_back(cyc);
    if (done)   begin dq.push_back(cyc);  eq.push_back(err);    end
    if (done_t) begin d2q.push_back(cyc); e2q.push_back(err_t); end
    if (!en_s && (aip_write || aip_read || aip_start || wr_ready || rd_valid || done)) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit to_inst, input logic [1:0] op, input logic [CW-1:0] cfg,
                       input int len, output int acc);
    int n;
    n = 0;
    while (!(to_inst ? cmd_ready_t : cmd_ready) && n < 50) begin step(); n++; end
    chk("cmd_ready_before_issue", to_inst ? cmd_ready_t : cmd_ready, 1);
    cmd_op = op; cmd_cfg = cfg; cmd_len = LW'(len);
    if (to_inst) cmd_valid_to = 1'b1; else cmd_valid = 1'b1;
    acc = cyc;
    step();
    cmd_valid = 1'b0; cmd_valid_to = 1'b0;
  endtask

  // mode 0: wr_valid always high; 1: bubble on the 2nd write cycle; 2: random bubbles
  task automatic run_write(input logic [CW-1:0] cfg, input int len, input int mode,
                           input logic [DW-1:0] base, input string tag);
    logic [DW-1:0] words[$];
    bit vp[$];
    int xc[$];
    int A, w0, d0, off, idx, lim, xd;
    lim = len * 3 + 8;
    for (int i = 0; i < len; i++) words.push_back((base != '0) ? base + DW'(i) : DW'($urandom));
    for (int i = 0; i <= lim; i++)
      vp.push_back((mode == 0 || i > len * 2 + 2) ? 1'b1 : (mode == 1) ? (i != 3) : ($urandom_range(0, 2) != 0));
    for (int o = 2; o <= lim && xc.size() < len; o++) if (vp[o]) xc.push_back(o);
    xd = (len > 0) ? xc[len-1] + 1 : 2;
    w0 = wq.size(); d0 = dq.size();
    issue(1'b0, OP_WRITE, cfg, len, A);
    off = 1; idx = 0;
    while (dq.size() == d0 && off < lim) begin
      wr_valid = vp[off] && (idx < len);
      wr_data  = '0;
      if (idx < len) wr_data = words[idx];
      #3;
      if (wr_valid && wr_ready) idx++;
      step();
      off++;
    end
    wr_valid = 1'b0;
    chk({tag, "_done_seen"}, dq.size() - d0, 1);
    chk({tag, "_nwrites"}, wq.size() - w0, len);
    for (int i = 0; i < len && w0 + i < wq.size(); i++) begin
      chk($sformatf("%s_wdata%0d", tag, i), wq[w0+i].d, words[i]);
      chk($sformatf("%s_wcyc%0d", tag, i), wq[w0+i].cyc - A, xc[i]);
      chk($sformatf("%s_wcfg%0d", tag, i), wq[w0+i].cfg, cfg);
    end
    if (dq.size() > d0) begin
      chk({tag, "_done_cyc"}, dq[d0] - A, xd);
      chk({tag, "_err"}, eq[d0], 0);
    end
  endtask

  task automatic run_read(input logic [CW-1:0] cfg, input int len, input logic [DW-1:0] salt,
                          input bit gap, input string tag);
    bit enp[$];
    int e[$];
    int A, r0, v0, d0, off, lim, xd;
    lim = len * 2 + 12;
    for (int i = 0; i <= lim; i++) enp.push_back(!(gap && (i == 3 || i == 4)));
    for (int i = 2; i <= lim; i++) if (enp[i]) e.push_back(i);
    xd = (len > 0) ? e[len+1] : e[0];
    r0 = rq.size(); v0 = vq.size(); d0 = dq.size();
    dbase = salt - DW'(rd_idx);
    issue(1'b0, OP_READ, cfg, len, A);
    off = 1;
    while (dq.size() == d0 && off < lim) begin
      en_s = enp[off];
      step();
      off++;
    end
    en_s = 1'b1;
    chk({tag, "_done_seen"}, dq.size() - d0, 1);
    chk({tag, "_nreads"}, rq.size() - r0, len);
    chk({tag, "_nvalid"}, vq.size() - v0, len);
    for (int i = 0; i < len && r0 + i < rq.size(); i++) begin
      chk($sformatf("%s_rcyc%0d", tag, i), rq[r0+i].cyc - A, e[i]);
      chk($sformatf("%s_rcfg%0d", tag, i), rq[r0+i].cfg, cfg);
    end
    for (int i = 0; i < len && v0 + i < vq.size(); i++) begin
      chk($sformatf("%s_vdata%0d", tag, i), vq[v0+i].d, salt + DW'(i));
      chk($sformatf("%s_vcyc%0d", tag, i), vq[v0+i].cyc - A, e[i+1]);
    end
    if (dq.size() > d0) begin
      chk({tag, "_done_cyc"}, dq[d0] - A, xd);
      chk({tag, "_err"}, eq[d0], 0);
    end
  endtask

  task automatic run_start(input logic [CW-1:0] cfg);
    int A, s0, d0, n;
    s0 = sq.size(); d0 = dq.size();
    issue(1'b0, OP_START, cfg, 0, A);
    n = 0;
    while (dq.size() == d0 && n < 20) begin step(); n++; end
    chk("start_done_seen", dq.size() - d0, 1);
    chk("start_pulses", sq.size() - s0, 1);
    if (sq.size() > s0) chk("start_cyc", sq[s0] - A, 2);
    if (dq.size() > d0) begin
      chk("start_done_cyc", dq[d0] - A, 3);
      chk("start_err", eq[d0], 0);
    end
  endtask

  // k: offset from accept at which int_req rises and stays high until done
  task automatic run_wait(input bit to_inst, input int k, input string tag);
    int A, d0, off, T, kk, xd;
    logic xe;
    T  = to_inst ? 8 : 65535;
    kk = (k < 2) ? 2 : k;
    xe = (kk > T + 1);
    xd = xe ? T + 2 : kk + 1;
    d0 = to_inst ? d2q.size() : dq.size();
    issue(to_inst, OP_WAIT_INT, CFG_STATUS, 0, A);
    off = 1;
    while ((to_inst ? d2q.size() : dq.size()) == d0 && off < xd + 5) begin
      aip_int_req = (off >= k);
      step();
      off++;
    end
    aip_int_req = 1'b0;
    if (to_inst) begin
      chk({tag, "_done_seen"}, d2q.size() - d0, 1);
      if (d2q.size() > d0) begin
        chk({tag, "_done_cyc"}, d2q[d0] - A, xd);
        chk({tag, "_err"}, e2q[d0], xe);
      end
    end else begin
      chk({tag, "_done_seen"}, dq.size() - d0, 1);
      if (dq.size() > d0) begin
        chk({tag, "_done_cyc"}, dq[d0] - A, xd);
        chk({tag, "_err"}, eq[d0], xe);
      end
    end
  endtask

  initial begin
    int A, d0, op_r, len_r;
    logic [CW-1:0] cfg_r;
    rst_a = 1'b1; en_s = 1'b1; cmd_valid = 1'b0; cmd_valid_to = 1'b0;
    cmd_op = '0; cmd_cfg = '0; cmd_len = '0; wr_data = '0; wr_valid = 1'b0; aip_int_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {cmd_ready, wr_ready, rd_valid, done, err, busy, aip_write, aip_read, aip_start}, 0);
    chk("reset_conf", aip_conf_dbus, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_data_out", aip_data_out, 0);
    rst_a = 1'b0;
    chk("ready_lag_after_reset", cmd_ready, 0);
    step();
    chk("ready_after_reset", cmd_ready, 1);

    run_write(CFG_MEMIN0, 4, 0, 32'hA0, "wr4");
    run_write(CFG_MEMIN0, 3, 1, 32'hB0, "wr3_bubble");
    run_write(CFG_CONFREG, 0, 0, 32'hC0, "wr_len0");
    run_read(CFG_MEMOUT0, 5, 32'h100, 1'b0, "rd5");
    run_read(CFG_MEMOUT0, 0, 32'h200, 1'b0, "rd_len0");
    run_read(CFG_IPID, 4, DW'($urandom), 1'b1, "rd_en_gap");
    run_start(CFG_CONFREG);
    run_wait(1'b0, 20, "wait_int20");
    run_wait(1'b1, 1000, "wait_timeout");
    run_wait(1'b1, 9, "wait_int_at_timeout");

    for (int it = 0; it < 10; it++) begin
      op_r  = $urandom_range(0, 3);
      len_r = $urandom_range(0, 6);
      cfg_r = CW'($urandom);
      case (op_r)
        0:       run_write(cfg_r, len_r, 2, '0, "rnd_wr");
        1:       run_read(cfg_r, len_r, DW'($urandom), 1'($urandom_range(0, 1)), "rnd_rd");
        2:       run_start(cfg_r);
        default: run_wait(1'b1, $urandom_range(2, 13), "rnd_wait");
      endcase
    end

    d0 = dq.size();
    dbase = 32'h100 - DW'(rd_idx);
    issue(1'b0, OP_READ, CFG_MEMOUT0, 5, A);
    step();
    step();
    chk("midrd_read_active", aip_read, 1);
    rst_a = 1'b1;
    #1;
    chk("midrd_reset_strobes", {aip_read, aip_write, aip_start, rd_valid, done, busy, cmd_ready, wr_ready}, 0);
    chk("midrd_reset_conf", aip_conf_dbus, 0);
    step();
    step();
    rst_a = 1'b0;
    chk("midrd_ready_lag", cmd_ready, 0);
    step();
    chk("midrd_ready_after", cmd_ready, 1);
    chk("midrd_no_done", dq.size() - d0, 0);
    run_write(CFG_MEMIN0, 1, 0, 32'h55, "post_reset_wr1");

    chk("quiet_while_disabled", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
